sdram_arbiter: RTL and testbench

Two-client arbiter that shares a single `sdram_controller` request interface between two independent requesters, e.g. a pixel fetcher and a host write path. It accepts one read or write per client, serialises them onto the controller's write/read request/acknowledge handshake, and returns completion and read data to the granted client. It sits directly between the client logic and the `sdram_controller` instance, replacing the single-user request FSM in the top level.

---
 rtl/sdram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one sdram_controller read/write request interface between two
//   clients. Each client posts a single read or write (req held until its
//   ack); the arbiter latches the winning request, drives it onto the
//   controller handshake, and returns a one-cycle ack plus read data.
//
// Optional feature macro: SDRAM_ARB_RR_EN
//   defined   : round-robin on simultaneous requests (first win after reset
//               goes to client 0).
//   undefined : fixed priority, client 0 always wins.
//
// Ports
//   iclk, ireset_n                  clock, async active-low reset
//   ic{0,1}_req/_we/_address/_wdata client request inputs
//   oc{0,1}_ack, oc{0,1}_rdata      client completion pulse and read data
//   owrite_req/_address/_data       controller write request
//   iwrite_ack                      controller write acknowledge
//   oread_req/_address              controller read request
//   iread_data, iread_ack           controller read data and acknowledge
//   ogrant                          one-hot grant (bit0 = client 0), 0 idle
//   obusy                           high whenever not in IDLE
//
// States
//   IDLE  | waiting for a client request with both controller acks low
//   WRITE | owrite_req driven, waiting for iwrite_ack
//   READ  | oread_req driven, waiting for iread_ack
//   DONE  | one-cycle ack to the granted client

module sdram_arbiter #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 128
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              ic0_req,
  input  logic              ic1_req,
  input  logic              ic0_we,
  input  logic              ic1_we,
  input  logic [ADDR_W-1:0] ic0_address,
  input  logic [ADDR_W-1:0] ic1_address,
  input  logic [DATA_W-1:0] ic0_wdata,
  input  logic [DATA_W-1:0] ic1_wdata,
  output logic              oc0_ack,
  output logic              oc1_ack,
  output logic [DATA_W-1:0] oc0_rdata,
  output logic [DATA_W-1:0] oc1_rdata,
  output logic              owrite_req,
  output logic [ADDR_W-1:0] owrite_address,
  output logic [DATA_W-1:0] owrite_data,
  input  logic              iwrite_ack,
  output logic              oread_req,
  output logic [ADDR_W-1:0] oread_address,
  input  logic [DATA_W-1:0] iread_data,
  input  logic              iread_ack,
  output logic [1:0]        ogrant,
  output logic              obusy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t            state, state_nxt;
  logic              start;
  logic              win;        // 0 = client 0 wins, 1 = client 1 wins
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

`ifdef SDRAM_ARB_RR_EN
  logic last_srv;              // client served most recently
  // On contention the client that was not served last wins.
  assign win = ic1_req & (~ic0_req | ~last_srv);
`else
  assign win = ic1_req & ~ic0_req;
`endif

  assign sel_we    = win ? ic1_we      : ic0_we;
  assign sel_addr  = win ? ic1_address : ic0_address;
  assign sel_wdata = win ? ic1_wdata   : ic0_wdata;

  // Latched request feeds the controller directly, so the granted client
  // is free to change its inputs after the grant.
  assign owrite_address = lat_addr;
  assign oread_address  = lat_addr;
  assign owrite_data    = lat_wdata;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        // A lingering controller ack from the previous transfer blocks a
        // new start so it cannot be mistaken for the new one's ack.
        if ((ic0_req | ic1_req) && !iwrite_ack && !iread_ack) begin
          start     = 1'b1;
          state_nxt = sel_we ? WRITE : READ;
        end
      end
      WRITE:   if (iwrite_ack) state_nxt = DONE;
      READ:    if (iread_ack)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      ogrant     <= 2'b00;
      owrite_req <= 1'b0;
      oread_req  <= 1'b0;
      obusy      <= 1'b0;
      oc0_ack    <= 1'b0;
      oc1_ack    <= 1'b0;
      oc0_rdata  <= '0;
      oc1_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        ogrant    <= win ? 2'b10 : 2'b01;
      end else if (state_nxt == IDLE) begin
        ogrant <= 2'b00;
      end
      // Moore outputs registered from the next state.
      owrite_req <= (state_nxt == WRITE);
      oread_req  <= (state_nxt == READ);
      obusy      <= (state_nxt != IDLE);
      oc0_ack    <= (state_nxt == DONE) & ogrant[0];
      oc1_ack    <= (state_nxt == DONE) & ogrant[1];
      if (state == READ && iread_ack) begin
        if (ogrant[1]) oc1_rdata <= iread_data;
        else           oc0_rdata <= iread_data;
      end
    end
  end

`ifdef SDRAM_ARB_RR_EN
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n)          last_srv <= 1'b1;
    else if (state == DONE) last_srv <= ogrant[1];
  end
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Drives two randomized clients and a randomized controller responder
//   against sdram_arbiter. A transaction-level model (pending requests,
//   arbitration rule, expected read data) predicts grants, controller
//   request contents and client acks cycle by cycle.

module tb_sdram_arbiter;
  localparam int AW = 22;
  localparam int DW = 128;

  logic          iclk = 1'b0;
  logic          ireset_n;
  logic          ic0_req, ic1_req, ic0_we, ic1_we;
  logic [AW-1:0] ic0_address, ic1_address;
  logic [DW-1:0] ic0_wdata, ic1_wdata;
  logic          oc0_ack, oc1_ack;
  logic [DW-1:0] oc0_rdata, oc1_rdata;
  logic          owrite_req, oread_req;
  logic [AW-1:0] owrite_address, oread_address;
  logic [DW-1:0] owrite_data;
  logic          iwrite_ack, iread_ack;
  logic [DW-1:0] iread_data;
  logic [1:0]    ogrant;
  logic          obusy;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .iclk(iclk), .ireset_n(ireset_n),
    .ic0_req(ic0_req), .ic1_req(ic1_req), .ic0_we(ic0_we), .ic1_we(ic1_we),
    .ic0_address(ic0_address), .ic1_address(ic1_address),
    .ic0_wdata(ic0_wdata), .ic1_wdata(ic1_wdata),
    .oc0_ack(oc0_ack), .oc1_ack(oc1_ack),
    .oc0_rdata(oc0_rdata), .oc1_rdata(oc1_rdata),
    .owrite_req(owrite_req), .owrite_address(owrite_address),
    .owrite_data(owrite_data), .iwrite_ack(iwrite_ack),
    .oread_req(oread_req), .oread_address(oread_address),
    .iread_data(iread_data), .iread_ack(iread_ack),
    .ogrant(ogrant), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic          pend [2];
  logic          m_we [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] exp_rd [2];
  int            last_srv;
  int            grant_log [$];

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic drive_client(input int c);
    if (c == 0) begin
      ic0_req = pend[0]; ic0_we = m_we[0]; ic0_address = m_addr[0]; ic0_wdata = m_wdata[0];
    end else begin
      ic1_req = pend[1]; ic1_we = m_we[1]; ic1_address = m_addr[1]; ic1_wdata = m_wdata[1];
    end
  endtask

  task automatic new_req(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[c] = 1'b1; m_we[c] = we; m_addr[c] = a; m_wdata[c] = d;
    drive_client(c);
  endtask

  task automatic rand_req(input int c);
    new_req(c, 1'($urandom_range(0, 1)), AW'($urandom), rand128());
  endtask

  // Which pending client should the arbiter pick
  function automatic int pick();
    if (pend[0] && pend[1]) begin
`ifdef SDRAM_ARB_RR_EN
      return (last_srv == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return pend[0] ? 0 : 1;
  endfunction

  task automatic clear_acks();
    iwrite_ack = 1'b0;
    iread_ack  = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wreq"}, DW'(owrite_req), DW'(0));
    chk({tag, "_rreq"}, DW'(oread_req), DW'(0));
    chk({tag, "_ack0"}, DW'(oc0_ack), DW'(0));
    chk({tag, "_ack1"}, DW'(oc1_ack), DW'(0));
  endtask

  // Entered 1 time unit after the edge at which a request should have been
  // granted. mode: 0 = no follow-up request, 1 = random, 2 = every client.
  task automatic txn(input int lat, input int hold, input logic [DW-1:0] rdat, input int mode);
    int            w;
    int            s;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    w = pick(); we = m_we[w]; addr = m_addr[w]; wdata = m_wdata[w];
    grant_log.push_back(w);
    chk("start_wreq", DW'(owrite_req), DW'(we));
    chk("start_rreq", DW'(oread_req), DW'(!we));
    if (we) begin
      chk("wr_addr", DW'(owrite_address), DW'(addr));
      chk("wr_data", owrite_data, wdata);
    end else begin
      chk("rd_addr", DW'(oread_address), DW'(addr));
    end
    chk("grant", DW'(ogrant), DW'((w == 0) ? 2'b01 : 2'b10));
    chk("busy", DW'(obusy), DW'(1));
    // Granted client scribbles on its inputs; must be ignored.
    if (w == 0) begin ic0_address = AW'($urandom); ic0_wdata = rand128(); end
    else        begin ic1_address = AW'($urandom); ic1_wdata = rand128(); end
    for (int i = 0; i < lat; i++) begin
      if (i == 0 && lat >= 2) begin
        if (we) iread_ack = 1'b1; else iwrite_ack = 1'b1;
      end
      step();
      clear_acks();
      chk("hold_req", DW'(we ? owrite_req : oread_req), DW'(1));
      chk("hold_other", DW'(we ? oread_req : owrite_req), DW'(0));
      chk("hold_addr", DW'(we ? owrite_address : oread_address), DW'(addr));
      chk("hold_ack0", DW'(oc0_ack), DW'(0));
      chk("hold_ack1", DW'(oc1_ack), DW'(0));
    end
    if (we) iwrite_ack = 1'b1;
    else begin iread_ack = 1'b1; iread_data = rdat; end
    step();
    iread_data = rand128();
    if (!we) exp_rd[w] = rdat;
    chk("done_wreq", DW'(owrite_req), DW'(0));
    chk("done_rreq", DW'(oread_req), DW'(0));
    chk("done_ack0", DW'(oc0_ack), DW'(w == 0));
    chk("done_ack1", DW'(oc1_ack), DW'(w == 1));
    chk("done_grant", DW'(ogrant), DW'((w == 0) ? 2'b01 : 2'b10));
    chk("done_busy", DW'(obusy), DW'(1));
    chk("rdata0", oc0_rdata, exp_rd[0]);
    chk("rdata1", oc1_rdata, exp_rd[1]);
    last_srv = w;
    pend[w]  = 1'b0;
    drive_client(w);
    if (mode == 0) begin
      pend[0] = 1'b0; pend[1] = 1'b0;
      drive_client(0); drive_client(1);
    end else begin
      for (int c = 0; c < 2; c++)
        if (!pend[c] && (mode == 2 || $urandom_range(0, 3) != 0)) rand_req(c);
      if (!pend[0] && !pend[1]) rand_req(int'($urandom_range(0, 1)));
    end
    if (hold == 1) clear_acks();
    s = (hold > 2) ? hold : 2;
    for (int k = 1; k < s; k++) begin
      step();
      if (k == hold - 1) clear_acks();
      chk_idle_outputs("gap");
      if (k == 1) begin
        chk("gap_busy", DW'(obusy), DW'(0));
        chk("gap_grant", DW'(ogrant), DW'(0));
      end
    end
    step();
    if (mode == 0) begin
      for (int k = 0; k < 2; k++) begin
        chk_idle_outputs("quiet");
        chk("quiet_busy", DW'(obusy), DW'(0));
        chk("keep_rdata0", oc0_rdata, exp_rd[0]);
        chk("keep_rdata1", oc1_rdata, exp_rd[1]);
        step();
      end
    end
  endtask

  initial begin
    ireset_n = 1'b0;
    ic0_req = 1'b0; ic1_req = 1'b0; ic0_we = 1'b0; ic1_we = 1'b0;
    ic0_address = '0; ic1_address = '0; ic0_wdata = '0; ic1_wdata = '0;
    iwrite_ack = 1'b0; iread_ack = 1'b0; iread_data = '0;
    for (int c = 0; c < 2; c++) begin
      pend[c] = 1'b0; m_we[c] = 1'b0; m_addr[c] = '0; m_wdata[c] = '0; exp_rd[c] = '0;
    end
    last_srv = 1;

    #2;
    chk_idle_outputs("rst");
    chk("rst_grant", DW'(ogrant), DW'(0));
    chk("rst_busy", DW'(obusy), DW'(0));
    chk("rst_waddr", DW'(owrite_address), DW'(0));
    chk("rst_wdata", owrite_data, DW'(0));
    chk("rst_raddr", DW'(oread_address), DW'(0));
    chk("rst_rdata0", oc0_rdata, DW'(0));
    chk("rst_rdata1", oc1_rdata, DW'(0));
    step(); step();
    ireset_n = 1'b1;
    step();

    // Single write: client 0, address 2, data 0x5A, controller ack after 6
    new_req(0, 1'b1, AW'(2), DW'(8'h5A));
    step();
    txn(6, 1, rand128(), 0);

    // Single read: client 1, address 3, controller returns 0xA5
    new_req(1, 1'b0, AW'(3), rand128());
    step();
    txn(2, 1, DW'(8'hA5), 0);

    // Held controller ack with another request waiting
    new_req(0, 1'b1, AW'($urandom), rand128());
    step();
    txn(3, 3, rand128(), 1);
    txn(1, 2, rand128(), 0);

    // Randomized traffic
    rand_req(int'($urandom_range(0, 1)));
    if ($urandom_range(0, 1) == 1 && !pend[1]) rand_req(1);
    step();
    for (int i = 0; i < 40; i++)
      txn(int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), rand128(), (i == 39) ? 0 : 1);

    // Reset while in READ
    new_req(1, 1'b0, AW'($urandom), rand128());
    step();
    chk("mid_rreq", DW'(oread_req), DW'(1));
    step(); step();
    ireset_n = 1'b0;
    #1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    chk("rst_mid_rreq", DW'(oread_req), DW'(0));
    chk("rst_mid_grant", DW'(ogrant), DW'(0));
    chk("rst_mid_busy", DW'(obusy), DW'(0));
    chk("rst_mid_rdata0", oc0_rdata, DW'(0));
    chk("rst_mid_rdata1", oc1_rdata, DW'(0));
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_client(0); drive_client(1);
    last_srv = 1;
    step();
    chk_idle_outputs("rst_hold");
    step();
    ireset_n = 1'b1;
    step();
    chk_idle_outputs("rst_rel");

    // Contention: both clients request continuously for 4 transactions
    grant_log.delete();
    rand_req(0); rand_req(1);
    step();
    for (int i = 0; i < 4; i++)
      txn(int'($urandom_range(0, 3)), 1, rand128(), (i == 3) ? 0 : 2);
    for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_RR_EN
      chk("contention_order", DW'(grant_log[i]), DW'(i % 2));
`else
      chk("contention_order", DW'(grant_log[i]), DW'(0));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case the flow above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
